// File: rtl/multdiv_pkg.sv
// Shared definitions for the multicycle multiply/divide unit and the control FSM that drives its op field.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIX   = 2'd2,
        DZERO = 2'd3
    } state_e;

    // op[OP_FUNC] selects multiply/divide, op[OP_SIGNED] selects two's-complement operands
    localparam int   OP_FUNC   = 0;
    localparam int   OP_SIGNED = 1;
    localparam logic OP_MUL    = 1'b0;
    localparam logic OP_DIV    = 1'b1;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[OP_FUNC] == OP_DIV;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/done handshake, operands and HI/LO results between the control FSM and mult_div_unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/multdiv_negate.sv
// Conditional two's-complement: passes val_i through, or negates it when en_i is set.
module multdiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] val_o
);

    // Negate-or-pass selection
    always_comb begin
        if (en_i) begin
            val_o = ~val_i + WIDTH'(1);
        end else begin
            val_o = val_i;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// WIDTH-generic signed/unsigned shift-add multiplier and restoring divider with HI/LO results.
// Optional build macro: MULTDIV_EARLY_OUT_EN (multiply stops once remaining multiplier bits are zero).
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    mult_div_unit_if.slave bus
);

    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;
    logic                 is_div_q, neg_res_q, neg_rem_q;
    logic [2*WIDTH-1:0]   acc_q, sh_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic                 sign_a_s, sign_b_s, start_div_s, last_s, div_bit_s;
    logic [WIDTH-1:0]     abs_a_s, abs_b_s, quo_fix_s, rem_fix_s;
    logic [WIDTH:0]       rem_sh_s, diff_s, div_rem_s;
    logic [2*WIDTH-1:0]   mul_sum_s, prod_fix_s;

    assign sign_a_s    = bus.op[OP_SIGNED] & bus.a[WIDTH-1];
    assign sign_b_s    = bus.op[OP_SIGNED] & bus.b[WIDTH-1];
    assign start_div_s = op_is_div(bus.op);

    multdiv_negate #(.WIDTH(WIDTH))     u_abs_a (.val_i(bus.a), .en_i(sign_a_s), .val_o(abs_a_s));
    multdiv_negate #(.WIDTH(WIDTH))     u_abs_b (.val_i(bus.b), .en_i(sign_b_s), .val_o(abs_b_s));
    multdiv_negate #(.WIDTH(2 * WIDTH)) u_fix_p (.val_i(acc_q), .en_i(neg_res_q), .val_o(prod_fix_s));
    multdiv_negate #(.WIDTH(WIDTH))     u_fix_q (.val_i(mplier_q), .en_i(neg_res_q), .val_o(quo_fix_s));
    multdiv_negate #(.WIDTH(WIDTH))     u_fix_r (.val_i(acc_q[WIDTH-1:0]), .en_i(neg_rem_q), .val_o(rem_fix_s));

    // One iteration step: shift-add for multiply, trial subtract for restoring divide
    always_comb begin
        if (mplier_q[0]) begin
            mul_sum_s = acc_q + sh_q;
        end else begin
            mul_sum_s = acc_q;
        end
        rem_sh_s  = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
        diff_s    = rem_sh_s - {1'b0, sh_q[WIDTH-1:0]};
        div_bit_s = ~diff_s[WIDTH];
        if (div_bit_s) begin
            div_rem_s = diff_s;
        end else begin
            div_rem_s = rem_sh_s;
        end
    end

    // Iteration exit condition; early-out multiplies stop once no multiplier bits remain
    always_comb begin
`ifdef MULTDIV_EARLY_OUT_EN
        if (is_div_q) begin
            last_s = (cnt_q == LAST);
        end else begin
            last_s = (mplier_q == {WIDTH{1'b0}});
        end
`else
        last_s = (cnt_q == LAST);
`endif
    end

    // Control FSM next-state and registered-output next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dz_d  = 1'b0;
                    cnt_d = {CNT_W{1'b0}};
                    if (start_div_s && (bus.b == {WIDTH{1'b0}})) begin
                        state_d = DZERO;
                    end else begin
                        state_d = ITER;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last_s) begin
                    state_d = FIX;
                end else begin
                    state_d = ITER;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            DZERO: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dz_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control state and status output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    // Datapath: latch magnitudes on start, iterate, write HI/LO only in FIX
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= {(2 * WIDTH){1'b0}};
            sh_q      <= {(2 * WIDTH){1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        is_div_q  <= start_div_s;
                        neg_res_q <= sign_a_s ^ sign_b_s;
                        neg_rem_q <= sign_a_s;
                        acc_q     <= {(2 * WIDTH){1'b0}};
                        if (start_div_s) begin
                            sh_q     <= {{WIDTH{1'b0}}, abs_b_s};
                            mplier_q <= abs_a_s;
                        end else begin
                            sh_q     <= {{WIDTH{1'b0}}, abs_a_s};
                            mplier_q <= abs_b_s;
                        end
                    end
                end
                ITER: begin
                    if (is_div_q) begin
                        acc_q    <= {{(WIDTH - 1){1'b0}}, div_rem_s};
                        mplier_q <= {mplier_q[WIDTH-2:0], div_bit_s};
                    end else begin
                        acc_q    <= mul_sum_s;
                        sh_q     <= sh_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                end
                FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix_s;
                        lo_q <= quo_fix_s;
                    end else begin
                        hi_q <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix_s[WIDTH-1:0];
                    end
                end
                default: begin
                    hi_q <= hi_q;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed WIDTH=32 checks plus a randomized WIDTH=8 sweep against an arithmetic reference model.
module tb_mult_div_unit;
    import multdiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] e_hi8, e_lo8;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) i32 ();
    mult_div_unit_if #(.WIDTH(8))  i8  ();

    mult_div_unit #(.WIDTH(32)) u_dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(i32.slave));
    mult_div_unit #(.WIDTH(8))  u_dut8  (.clk_i(clk), .rst_ni(rst_n), .bus(i8.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Edges from the start edge to the edge after which done is visible
    function automatic int exp_lat(input int w, input logic is_div, input logic [63:0] bmag);
        int hb;
        hb = -1;
        if (is_div && bmag == 64'd0) return 1;
`ifdef MULTDIV_EARLY_OUT_EN
        if (!is_div) begin
            for (int i = 0; i < w; i++) if (bmag[i]) hb = i;
            return (hb < 0) ? 2 : hb + 3;
        end
`endif
        return w + 1 + hb - hb;
    endfunction

    // Called at a negedge; issues one op and returns at the negedge where done is seen
    task automatic do_op32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic bok, output logic d0, output logic z0);
        i32.start = 1'b1; i32.op = op; i32.a = a; i32.b = b;
        @(negedge clk);
        i32.start = 1'b0; i32.a = $urandom; i32.b = $urandom; i32.op = 2'($urandom);
        d0 = i32.done; z0 = i32.div_zero;
        lat = 0; bok = 1'b1;
        while (!i32.done && lat < 80) begin
            if (!i32.busy) bok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op8_check(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, bmag, lat;
        logic [31:0] q, r;
        logic [15:0] p;
        logic e_dz, bok;
        sa = op[OP_SIGNED] ? int'($signed(a)) : int'(a);
        sb = op[OP_SIGNED] ? int'($signed(b)) : int'(b);
        bmag = (sb < 0) ? -sb : sb;
        e_dz = 1'b0;
        if (op[OP_FUNC] == OP_MUL) begin
            p = 16'(sa * sb);
            e_hi8 = p[15:8]; e_lo8 = p[7:0];
        end else if (sb == 0) begin
            e_dz = 1'b1;
        end else begin
            q = sa / sb; r = sa % sb;
            e_lo8 = q[7:0]; e_hi8 = r[7:0];
        end
        i8.start = 1'b1; i8.op = op; i8.a = a; i8.b = b;
        @(negedge clk);
        i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom); i8.op = 2'($urandom);
        lat = 0; bok = 1'b1;
        while (!i8.done && lat < 40) begin
            if (!i8.busy) bok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check($sformatf("w8_lat op=%0d a=%0h b=%0h", op, a, b), 64'(lat), 64'(exp_lat(8, op[OP_FUNC], 64'(bmag))));
        check($sformatf("w8_hi op=%0d a=%0h b=%0h", op, a, b), 64'(i8.hi), 64'(e_hi8));
        check($sformatf("w8_lo op=%0d a=%0h b=%0h", op, a, b), 64'(i8.lo), 64'(e_lo8));
        check("w8_dz", 64'(i8.div_zero), 64'(e_dz));
        check("w8_busy", 64'({bok, i8.busy}), 64'(2'b10));
    endtask

    initial begin
        int lat;
        logic bok, d0, z0, seen;
        logic [1:0] rop;
        logic [7:0] ra, rb;

        rst_n = 1'b0;
        i32.start = 1'b0; i32.op = 2'b00; i32.a = 32'd0; i32.b = 32'd0;
        i8.start  = 1'b0; i8.op  = 2'b00; i8.a  = 8'd0;  i8.b  = 8'd0;
        e_hi8 = 8'd0; e_lo8 = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(i32.busy), 64'd0);
        check("rst_done", 64'(i32.done), 64'd0);
        check("rst_dz", 64'(i32.div_zero), 64'd0);
        check("rst_hilo", {i32.hi, i32.lo}, 64'd0);
        check("rst_hilo8", 64'({i8.hi, i8.lo}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok, d0, z0);
        check("mulu_lat", 64'(lat), 64'(exp_lat(32, 1'b0, 64'h0000_0000_FFFF_FFFF)));
        check("mulu_busy", 64'({bok, i32.busy, i32.done}), 64'(3'b101));
        check("mulu_hi", 64'(i32.hi), 64'h0000_0000_FFFF_FFFE);
        check("mulu_lo", 64'(i32.lo), 64'h0000_0000_0000_0001);

        do_op32(2'b10, 32'hFFFF_FFF9, 32'd6, lat, bok, d0, z0);
        check("b2b_done_pulse", 64'(d0), 64'd0);
        check("muls_lat", 64'(lat), 64'(exp_lat(32, 1'b0, 64'd6)));
        check("muls_hilo", {i32.hi, i32.lo}, 64'hFFFF_FFFF_FFFF_FFD6);

        do_op32(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bok, d0, z0);
        check("divs_lat", 64'(lat), 64'd33);
        check("divs_hilo", {i32.hi, i32.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        do_op32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok, d0, z0);
        check("minneg1_hilo", {i32.hi, i32.lo}, 64'h0000_0000_8000_0000);
        check("minneg1_dz", 64'(i32.div_zero), 64'd0);

        do_op32(2'b01, 32'd1234, 32'd0, lat, bok, d0, z0);
        check("dz_lat", 64'(lat), 64'd1);
        check("dz_flag", 64'({i32.div_zero, i32.busy}), 64'(2'b10));
        check("dz_hilo_kept", {i32.hi, i32.lo}, 64'h0000_0000_8000_0000);

        do_op32(2'b01, 32'd100, 32'd7, lat, bok, d0, z0);
        check("dz_cleared_on_start", 64'(z0), 64'd0);
        check("divu_hilo", {i32.hi, i32.lo}, 64'h0000_0002_0000_000E);

        // start during busy must be ignored
        i32.start = 1'b1; i32.op = 2'b00; i32.a = 32'd12345; i32.b = 32'd678;
        @(negedge clk);
        i32.start = 1'b0; lat = 0;
        repeat (3) begin @(negedge clk); lat++; end
        i32.start = 1'b1; i32.op = 2'b01; i32.a = 32'd1; i32.b = 32'd0;
        @(negedge clk); lat++;
        i32.start = 1'b0;
        while (!i32.done && lat < 80) begin @(negedge clk); lat++; end
        check("ign_lat", 64'(lat), 64'(exp_lat(32, 1'b0, 64'd678)));
        check("ign_hilo", {i32.hi, i32.lo}, 64'd8369910);
        check("ign_dz", 64'(i32.div_zero), 64'd0);

        do_op32(2'b00, 32'd5, 32'd3, lat, bok, d0, z0);
        check("mul_b3_lat", 64'(lat), 64'(exp_lat(32, 1'b0, 64'd3)));
        check("mul_b3_lo", {i32.hi, i32.lo}, 64'd15);
        @(negedge clk);
        check("done_one_cycle", 64'(i32.done), 64'd0);

        // reset in the middle of ITER
        i32.start = 1'b1; i32.op = 2'b00; i32.a = 32'd77; i32.b = 32'hFFFF_0000;
        @(negedge clk);
        i32.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'({i32.busy, i32.done}), 64'd0);
        check("midrst_hilo", {i32.hi, i32.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (i32.done || i32.busy) seen = 1'b1; end
        check("midrst_no_done", 64'(seen), 64'd0);
        check("midrst_hilo_hold", {i32.hi, i32.lo}, 64'd0);
        e_hi8 = 8'd0; e_lo8 = 8'd0;

        op8_check(2'b11, 8'h80, 8'hFF);
        op8_check(2'b01, 8'h55, 8'h00);
        op8_check(2'b10, 8'h80, 8'h80);
        for (int n = 0; n < 150; n++) begin
            rop = 2'($urandom);
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            op8_check(rop, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multicycle integer multiply/divide unit for the multicycle datapath. It takes two WIDTH-bit operands from the A/B operand registers. It produces a 2·WIDTH-bit result in HI/LO registers for the memToReg path and mfhi/mflo. It replaces fixed 32-bit single-mode multiply logic with a WIDTH-generic, signed/unsigned, multiply-or-divide engine driven by a start/done handshake from the control FSM.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; legal range 4..64
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  request; sampled only in IDLE
- op  in  2  bit0: 0 = multiply, 1 = divide; bit1: 1 = signed, 0 = unsigned
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle completion pulse
- div_zero  out  1  sticky-until-next-start flag: last divide had b == 0
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient

## Operation
- States:
  - IDLE: start=1 and a divide with b==0 → DZERO; start=1 otherwise → ITER; start=0 → stay.
  - ITER: counter runs WIDTH cycles → FIX.
  - FIX → IDLE, with done=1 on exit.
  - DZERO → IDLE, with done=1 and div_zero=1.
- On start, the op and the operand magnitudes are latched (two's-complement absolute value when op[1]=1), along with the result sign.
  - Multiply sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Multiply: shift-add over WIDTH iterations, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- Divide: restoring division, one quotient bit per cycle; the remainder register is WIDTH+1 bits.
- FIX: conditionally negate the magnitude results, then write hi/lo.
  - Signed divide truncates toward zero.
  - MIN / −1 yields lo = MIN, hi = 0, with no exception.
- div_zero clears on every accepted start. On DZERO, hi and lo keep their previous values.
- start while busy is ignored, and operands are not re-sampled. a, b and op may change freely after the start edge.
- hi and lo change only in FIX; they hold between operations.

## Timing
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0, state IDLE, counter 0.
- Normal latency: start sampled at edge E0; busy=1 after E0; done=1 for exactly the cycle after edge E(WIDTH+1), with busy=0 in that same cycle and hi/lo valid.
- Divide-by-zero latency: done and div_zero are high in the cycle after E1.
- Back-to-back: start may be asserted during the done cycle and is accepted at the next edge. Throughput is one op per WIDTH+2 cycles.
- Reset mid-operation aborts immediately: no done pulse, and hi/lo return to 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MULTDIV_EARLY_OUT_EN defined: a multiply leaves ITER as soon as the remaining multiplier bits are all zero. Latency becomes (index of highest set bit of |b|)+3 edges; b==0 gives 2 edges. Divide latency is unchanged.
- MULTDIV_EARLY_OUT_EN undefined: multiply latency is fixed at WIDTH+1 edges. The early-out logic is absent.

## Structure
- Shared package multdiv_pkg holds:
  - the state enum (IDLE, ITER, FIX, DZERO);
  - op-encoding localparams (OP_MUL, OP_DIV, OP_SIGNED bit index).
- The control FSM imports the same package to drive op.
- One sub-module, multdiv_negate: a parametrised conditional two's-complement (width and enable). It is instantiated for operand absolute values and for result sign fixing.

## Test plan
- WIDTH=32, unsigned mul, a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after start; busy high throughout.
- Signed mul, a=−7, b=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6; signed div a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- Div with b=0 → done and div_zero one edge after start; hi/lo unchanged from the previous op. The next start clears div_zero.
- start re-asserted with new operands during busy → ignored, first result intact. Reset pulsed mid-ITER → no done, hi=lo=0, busy=0. With MULTDIV_EARLY_OUT_EN, unsigned mul b=3 → done after 4 edges.
- WIDTH=8 random signed/unsigned mul/div sweep against a reference model; each result checked at its done pulse.
